// File: rtl/foo_egress_pkg.sv
// Shared types, default parameters and pointer helper
// for the foo egress buffer.
package foo_egress_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_DEPTH        = 4;
  localparam int DEF_PIPE_LATENCY = 3;
  localparam int DEF_CW           = $clog2(DEF_DEPTH + 1);

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_CW-1:0]     cnt_t;

  // Wrap by explicit compare so non-power-of-2 depths work.
  function automatic int unsigned ptr_inc(
    input int unsigned ptr,
    input int unsigned depth
  );
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/foo_egress_fifo.sv
// Registered-output FIFO holding foo pipeline results.
// Head is presented the cycle after write; no fall-through.
module foo_egress_fifo
  import foo_egress_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     occ_q, occ_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              full;
  logic              pop;
  logic              push_acc;

  // Next-state for storage, pointers, count and registered head.
  always_comb begin
    full     = (occ_q == CW'(DEPTH));
    pop      = out_valid_q && out_ready;
    push_acc = push && (!full || pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
    end
    if (pop) begin
      rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
    end
    case ({push_acc, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
    out_valid_d = (occ_d != '0);
    out_data_d  = out_data_q;
    if (occ_d != '0) begin
      // The slot being written this edge becomes head only if
      // it is the sole remaining entry.
      if (push_acc && (rd_ptr_d == wr_ptr_q)) begin
        out_data_d = push_data;
      end else begin
        out_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign occupancy = occ_q;

endmodule

// File: rtl/foo_egress_buffer.sv
// Credit-managed egress buffer for the non-stallable foo pipeline.
// Optional sticky err output under FOO_EGRESS_ERR_EN.
module foo_egress_buffer
  import foo_egress_pkg::*;
#(
  parameter  int DATA_W       = DEF_DATA_W,
  parameter  int DEPTH        = DEF_DEPTH,
  parameter  int PIPE_LATENCY = DEF_PIPE_LATENCY,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              pipe_valid,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     occupancy
`ifdef FOO_EGRESS_ERR_EN
  ,
  output logic              err
`endif
);

  // Inflight never legally exceeds min(DEPTH, PIPE_LATENCY);
  // the cap only keeps illegal traffic from wrapping the counter.
  localparam int CAP_RAW =
    (PIPE_LATENCY > DEPTH) ? PIPE_LATENCY : DEPTH;
  localparam int CAP_MAX = (2 ** CW) - 1;
  localparam int INFL_CAP =
    (CAP_RAW > CAP_MAX) ? CAP_MAX : CAP_RAW;

  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW:0]   used;

  foo_egress_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_valid),
    .push_data (pipe_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // Credit accounting; issue_ready depends on registers only.
  always_comb begin
    inflight_d = inflight_q;
    if (issue_valid && !pipe_valid) begin
      if (inflight_q != CW'(INFL_CAP)) begin
        inflight_d = inflight_q + CW'(1);
      end
    end else if (!issue_valid && pipe_valid) begin
      if (inflight_q != '0) begin
        inflight_d = inflight_q - CW'(1);
      end
    end
    used        = {1'b0, occupancy} + {1'b0, inflight_q};
    issue_ready = (used < (CW + 1)'(DEPTH));
  end

  // Inflight counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

`ifdef FOO_EGRESS_ERR_EN
  logic err_q, err_d;
  logic overflow;

  // Sticky protocol-violation flag.
  always_comb begin
    overflow = pipe_valid
            && (occupancy == CW'(DEPTH))
            && !(out_valid && out_ready);
    err_d = err_q
         || overflow
         || (issue_valid && !issue_ready)
         || (pipe_valid && (inflight_q == '0))
         || (int'(inflight_q) > PIPE_LATENCY);
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_foo_egress_buffer.sv
// Scoreboard bench for foo_egress_buffer with a
// behavioural 3-stage pipeline model feeding it.
module tb_foo_egress_buffer;
  import foo_egress_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic          issue_ready;
  logic          pipe_valid;
  data_t         pipe_data;
  logic          out_valid;
  logic          out_ready;
  data_t         out_data;
  logic [CW-1:0] occupancy;
`ifdef FOO_EGRESS_ERR_EN
  logic          err;
`endif

  int    n_chk  = 0;
  int    n_fail = 0;
  data_t sb[$];
  bit    sv[LAT];
  data_t sd[LAT];
  data_t nxt;
  int    infl;
  int    ndrop;
  bit    frc_v;
  data_t frc_d;
  int    n_iss;

  foo_egress_buffer #(
    .DATA_W       (32),
    .DEPTH        (DEPTH),
    .PIPE_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .pipe_valid  (pipe_valid),
    .pipe_data   (pipe_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .occupancy   (occupancy)
`ifdef FOO_EGRESS_ERR_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    for (int i = 0; i < LAT; i++) begin
      sv[i] = 1'b0;
      sd[i] = '0;
    end
    infl = 0;
  endtask

  task automatic step();
    bit pop;
    pipe_valid = sv[LAT-1] || frc_v;
    pipe_data  = frc_v ? frc_d : sd[LAT-1];
    pop = out_valid && out_ready;
    if (pop) begin
      if (sb.size() == 0) chk("pop_empty", 1, 0);
      else chk("pop_data", out_data, sb.pop_front());
    end
    if (pipe_valid) begin
      if (sb.size() < DEPTH) sb.push_back(pipe_data);
      else ndrop++;
    end
    if (issue_valid && !pipe_valid) infl++;
    else if (!issue_valid && pipe_valid && infl > 0) infl--;
    for (int i = LAT - 1; i > 0; i--) begin
      sv[i] = sv[i-1];
      sd[i] = sd[i-1];
    end
    sv[0] = issue_valid;
    sd[0] = nxt;
    if (issue_valid) nxt = nxt + 1;
    @(posedge clk);
    #1;
    pipe_valid = 1'b0;
    chk("occ", occupancy, sb.size());
    chk("ovalid", out_valid, sb.size() != 0);
    chk("iready", issue_ready, (sb.size() + infl) < DEPTH);
    if (sb.size() != 0) chk("head", out_data, sb[0]);
  endtask

  initial begin
    rst         = 1'b0;
    issue_valid = 1'b0;
    pipe_valid  = 1'b0;
    pipe_data   = '0;
    out_ready   = 1'b0;
    frc_v       = 1'b0;
    frc_d       = '0;
    nxt         = 32'h1;
    ndrop       = 0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovalid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_iready", issue_ready, 1);
    chk("rst_odata", out_data, 0);
`ifdef FOO_EGRESS_ERR_EN
    chk("rst_err", err, 0);
`endif
    @(negedge clk);
    rst = 1'b1;

    n_iss = 0;
    for (int i = 0; i < 12; i++) begin
      issue_valid = issue_ready;
      if (issue_valid) n_iss++;
      step();
      if (n_iss == 4 && issue_valid) chk("ir_after_4th", issue_ready, 0);
    end
    issue_valid = 1'b0;
    chk("issues_accepted", n_iss, 4);
    chk("fill_occ", occupancy, 4);
    chk("fill_nodrop", ndrop, 0);

    out_ready = 1'b1;
    frc_v = 1'b1;
    frc_d = 32'h5;
    step();
    frc_v = 1'b0;
    chk("pp_full_occ", occupancy, 4);
    repeat (4) step();
    chk("pp_drained", occupancy, 0);
    out_ready = 1'b0;

    frc_v = 1'b1;
    frc_d = 32'hDEADBEEF;
    step();
    frc_v = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_data", out_data, 32'hDEADBEEF);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_gone", out_valid, 0);

    for (int i = 0; i < 12; i++) begin
      issue_valid = issue_ready;
      step();
    end
    issue_valid = 1'b0;
    chk("ovf_pre_occ", occupancy, 4);
    frc_v = 1'b1;
    frc_d = 32'h77;
    step();
    frc_v = 1'b0;
    chk("ovf_occ", occupancy, 4);
    chk("ovf_drop", ndrop, 1);
`ifdef FOO_EGRESS_ERR_EN
    chk("ovf_err", err, 1);
    repeat (3) step();
    chk("err_sticky", err, 1);
`endif
    out_ready = 1'b1;
    repeat (5) step();
    out_ready = 1'b0;
    chk("ovf_drained", occupancy, 0);

    for (int i = 0; i < 3; i++) begin
      frc_v = 1'b1;
      frc_d = 32'hA0 + i;
      step();
    end
    frc_v = 1'b0;
    issue_valid = 1'b1;
    repeat (2) step();
    issue_valid = 1'b0;
    chk("pre_rst_occ", occupancy, 3);
    chk("pre_rst_infl", infl, 2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_ovalid", out_valid, 0);
    chk("async_occ", occupancy, 0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("post_rst_iready", issue_ready, 1);
`ifdef FOO_EGRESS_ERR_EN
    chk("post_rst_err", err, 0);
`endif
    out_ready = 1'b1;
    repeat (6) step();
    chk("no_stale", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
